// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw lines, deframes 11-bit
// frames with start/parity/stop/timeout checks and queues good bytes in a FIFO.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2     = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       nextdata,
  output logic [7:0] code,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES);
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [2:0]            kclk;
  logic [1:0]            kdat;
  logic                  fall, bit_s, frame_ok;
  logic [3:0]            bcnt;
  logic [9:0]            sr;
  logic [TW-1:0]         tcnt;
  logic                  push_q;
  logic [7:0]            push_data;

  logic [DEPTH-1:0][7:0] mem;
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  pop, full, wr_ok;

  // The data line is only consumed at stage 2, so its chain stops there.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      kclk <= 3'b111;
      kdat <= 2'b11;
    end else begin
      kclk <= {kclk[1:0], ps2_clk};
      kdat <= {kdat[0], ps2_dat};
    end
  end

  assign fall  = !kclk[1] && kclk[2];
  assign bit_s = kdat[1];
  // sr holds bits 0..9 (start at sr[0]); bit_s is the stop bit on the last edge
  assign frame_ok = !sr[0] && (^sr[9:1]) && bit_s;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bcnt      <= '0;
      sr        <= '0;
      tcnt      <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (bcnt == 4'd0 && bit_s) begin
          frame_err <= 1'b1;
        end else if (bcnt == 4'd10) begin
          bcnt <= '0;
          if (frame_ok) begin
            push_q    <= 1'b1;
            push_data <= sr[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          sr   <= {bit_s, sr[9:1]};
          bcnt <= bcnt + 4'd1;
        end
      end else if (bcnt != 4'd0) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bcnt      <= '0;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

  assign ready = (cnt != '0);
  assign code  = mem[rd_ptr];
  assign pop   = ready && !nextdata;
  assign full  = (cnt == CW'(DEPTH));
  // A concurrent pop frees the slot, so a full FIFO still accepts the push.
  assign wr_ok = push_q && (!full || pop);

  always_comb begin
    cnt_nxt = cnt;
    if (wr_ok && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!wr_ok && pop) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mem      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (wr_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (pop)                 overflow <= 1'b0;
      else if (push_q && !wr_ok) overflow <= 1'b1;
    end
  end
endmodule
